// File: rtl/ren_params.sv
// Shared constants for the tile walker.
// State codes, legal tile edges and default screen size.
package ren_params;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_EMIT,
      S_DONE
   } state_t;

   localparam int TS_1  = 1;
   localparam int TS_2  = 2;
   localparam int TS_4  = 4;
   localparam int TS_8  = 8;
   localparam int TS_16 = 16;

   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;

endpackage

// File: rtl/ren_tile_size_sel.sv
// Maps a box extent to the smallest power-of-two
// tile edge covering it, capped at TILE_SIZE.
module ren_tile_size_sel
   import ren_params::*;
#(
   parameter int TILE_SIZE = TS_16,
   parameter int EXT_W     = 13
) (
   input  logic [EXT_W-1:0] ext,
   output logic [15:0]      size
);

   logic [31:0] ext32;
   logic [15:0] cand;

   assign ext32 = 32'(ext);

   // smallest legal edge that is >= ext
   always_comb begin
      if (ext32 <= 32'(TS_1))
         cand = 16'(TS_1);
      else if (ext32 <= 32'(TS_2))
         cand = 16'(TS_2);
      else if (ext32 <= 32'(TS_4))
         cand = 16'(TS_4);
      else if (ext32 <= 32'(TS_8))
         cand = 16'(TS_8);
      else
         cand = 16'(TS_16);
   end

   assign size = (cand > 16'(TILE_SIZE)) ?
                 16'(TILE_SIZE) : cand;

endmodule

// File: rtl/ren_tile_walker.sv
// Clamps a triangle bbox to the screen and walks
// its covering tiles in raster order.
module ren_tile_walker
   import ren_params::*;
#(
   parameter int TILE_SIZE = TS_16,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int SCREEN_H  = SCREEN_H_DEF,
   parameter int COORD_W   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [COORD_W-1:0] i_bbox_xmin,
   input  logic [COORD_W-1:0] i_bbox_xmax,
   input  logic [COORD_W-1:0] i_bbox_ymin,
   input  logic [COORD_W-1:0] i_bbox_ymax,
   input  logic               i_flush,
   output logic               o_valid,
   input  logic               i_ack,
   output logic [21:0]        o_tile_x,
   output logic [21:0]        o_tile_y,
   output logic [15:0]        o_tile_size,
   output logic               o_last,
   output logic               o_done
);

   localparam int AW = COORD_W + 1;
   localparam logic [COORD_W-1:0] XLIM =
      COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] YLIM =
      COORD_W'(SCREEN_H - 1);
   localparam logic [AW-1:0] WLIM = AW'(SCREEN_W);
   localparam logic [AW-1:0] HLIM = AW'(SCREEN_H);

   state_t state, state_nx;

   logic [COORD_W-1:0] xmin_q, xmax_q;
   logic [COORD_W-1:0] ymin_q, ymax_q;
   logic [COORD_W-1:0] x0_q, x_q, y_q;
   logic [15:0]        size_q;

   logic [COORD_W-1:0] xmaxc, ymaxc;
   logic [COORD_W-1:0] dx, dy, dmax;
   logic [AW-1:0]      ext;
   logic [15:0]        size_s;
   logic [COORD_W-1:0] mask;
   logic               empty;
   logic [AW-1:0]      nx, ny;
   logic               last;
   logic               ld_bbox, ld_setup;
   logic               step_x, step_y;

   assign xmaxc = (xmax_q > XLIM) ? XLIM : xmax_q;
   assign ymaxc = (ymax_q > YLIM) ? YLIM : ymax_q;

   assign empty = (xmin_q > xmaxc)
                | (ymin_q > ymaxc)
                | ({1'b0, xmin_q} >= WLIM)
                | ({1'b0, ymin_q} >= HLIM);

   assign dx   = xmaxc - xmin_q;
   assign dy   = ymaxc - ymin_q;
   assign dmax = (dx > dy) ? dx : dy;
   assign ext  = AW'(dmax) + AW'(1);

   ren_tile_size_sel #(
      .TILE_SIZE (TILE_SIZE),
      .EXT_W     (AW)
   ) u_size (
      .ext  (ext),
      .size (size_s)
   );

   assign mask = ~COORD_W'(size_s - 16'd1);

   // one extra bit so the step past the edge never wraps
   assign nx   = {1'b0, x_q} + AW'(size_q);
   assign ny   = {1'b0, y_q} + AW'(size_q);
   assign last = (nx > {1'b0, xmaxc})
               & (ny > {1'b0, ymaxc});

   assign o_tile_x    = 22'(x_q);
   assign o_tile_y    = 22'(y_q);
   assign o_tile_size = size_q;

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // next state, handshake outputs and datapath strobes
   always_comb begin
      state_nx = state;
      ld_bbox  = 1'b0;
      ld_setup = 1'b0;
      step_x   = 1'b0;
      step_y   = 1'b0;
      o_ready  = 1'b0;
      o_valid  = 1'b0;
      o_last   = 1'b0;
      o_done   = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               ld_bbox  = 1'b1;
               state_nx = S_SETUP;
            end
         end
         S_SETUP: begin
            if (i_flush)
               state_nx = S_IDLE;
            else if (empty)
               state_nx = S_DONE;
            else begin
               ld_setup = 1'b1;
               state_nx = S_EMIT;
            end
         end
         S_EMIT: begin
            o_valid = 1'b1;
            o_last  = last;
            if (i_flush)
               state_nx = S_IDLE;
            else if (i_ack) begin
               if (nx <= {1'b0, xmaxc})
                  step_x = 1'b1;
               else if (ny <= {1'b0, ymaxc})
                  step_y = 1'b1;
               else
                  state_nx = S_DONE;
            end
         end
         S_DONE: begin
            o_done   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // bbox latch, tile setup and raster stepping
   always_ff @(posedge clk) begin
      if (rst) begin
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         x0_q   <= '0;
         x_q    <= '0;
         y_q    <= '0;
         size_q <= 16'(TILE_SIZE);
      end else begin
         if (ld_bbox) begin
            xmin_q <= i_bbox_xmin;
            xmax_q <= i_bbox_xmax;
            ymin_q <= i_bbox_ymin;
            ymax_q <= i_bbox_ymax;
         end
         if (ld_setup) begin
            size_q <= size_s;
            x0_q   <= xmin_q & mask;
            x_q    <= xmin_q & mask;
            y_q    <= ymin_q & mask;
         end
         if (step_x)
            x_q <= nx[COORD_W-1:0];
         if (step_y) begin
            x_q <= x0_q;
            y_q <= ny[COORD_W-1:0];
         end
      end
   end

endmodule

// File: doc/ren_tile_walker.md
Name: ren_tile_walker

Overview:
- Upstream neighbour of the fragment shader stage.
- Accepts one triangle's integer pixel bounding box from triangle setup and clamps it to the screen.
- Selects a power-of-two tile size from 1 to TILE_SIZE and walks the covered tiles in raster order.
- Hands each tile origin and size to the fragment shader over a valid/ack handshake; signals completion so setup can issue the next triangle.

Parameters:
- TILE_SIZE, 16: maximum tile edge in pixels; power of two, range 1..16.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- COORD_W, 12: width of the integer bounding-box coordinates.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  bounding box present.
- o_ready  out  1  walker idle, can accept a bounding box.
- i_bbox_xmin  in  COORD_W  inclusive min x, unsigned pixels.
- i_bbox_xmax  in  COORD_W  inclusive max x.
- i_bbox_ymin  in  COORD_W  inclusive min y.
- i_bbox_ymax  in  COORD_W  inclusive max y.
- i_flush  in  1  abandon the current triangle.
- o_valid  out  1  tile presented to the fragment shader.
- i_ack  in  1  fragment shader consumed the tile (its o_ack).
- o_tile_x  out  22  tile origin x, unsigned integer pixels, zero-extended.
- o_tile_y  out  22  tile origin y.
- o_tile_size  out  16  tile edge, one of 16/8/4/2/1.
- o_last  out  1  current tile is the final tile of the triangle.
- o_done  out  1  one-cycle pulse: triangle fully walked.

Behaviour:
- Reset values: o_ready=1, o_valid=0, o_last=0, o_done=0, o_tile_x=0, o_tile_y=0, o_tile_size=TILE_SIZE. State S_IDLE.
- Reset mid-walk: next cycle every output takes its reset value, with no o_done.
- States: S_IDLE, S_SETUP, S_EMIT, S_DONE.
- S_IDLE: o_ready=1. On i_valid & o_ready, latch the bbox and go to S_SETUP. The accept cycle is cycle 0.
- S_SETUP (cycle 1), clamp: xmaxc = min(xmax, SCREEN_W-1); ymaxc = min(ymax, SCREEN_H-1). xmin and ymin are unsigned, so they need no lower clamp.
- S_SETUP, empty box: if xmin>xmaxc, ymin>ymaxc, xmin>=SCREEN_W or ymin>=SCREEN_H, go to S_DONE with no tiles emitted.
- S_SETUP, tile size: ext = max(xmaxc-xmin, ymaxc-ymin)+1; size = smallest power of two >= ext, capped at TILE_SIZE.
- S_SETUP, alignment: x0 = xmin & ~(size-1); y0 = ymin & ~(size-1). Current tile = (x0, y0). Go to S_EMIT.
- S_EMIT: o_valid=1 from cycle 2. o_tile_x, o_tile_y, o_tile_size and o_last are stable while i_ack=0.
- On i_ack: nx = x+size.
  - If nx <= xmaxc, next tile is (nx, y).
  - Otherwise ny = y+size; if ny <= ymaxc, next tile is (x0, ny).
  - Otherwise the walk is finished: go to S_DONE.
  - A new tile is presented the cycle after the ack, with o_valid held high (one tile per ack, no bubble).
- o_last: combinational from the current tile: (x+size > xmaxc) & (y+size > ymaxc).
- S_DONE: o_valid=0, o_done=1 for exactly one cycle, then S_IDLE. o_ready returns to 1 the cycle after o_done.
- i_flush in any non-idle state: next cycle S_IDLE, o_valid=0, no o_done.
- i_flush and i_ack in the same cycle: flush wins.
- i_flush in S_IDLE: ignored.
- i_ack while o_valid=0: ignored.
- Arithmetic: coordinate adders are COORD_W+1 bits so nx/ny cannot wrap; comparisons are unsigned.
- Tile size is fixed for the whole triangle; there is no per-tile subdivision.

Decomposition:
- Shared package (ren_params): state encodings S_IDLE..S_DONE; legal tile-size constants 1/2/4/8/16; SCREEN_W/SCREEN_H defaults.
- Optional sub-module ren_tile_size_sel: combinational ext-to-power-of-two with cap at TILE_SIZE. Keeps the FSM file focused.
- Integer-to-fp conversion of tile coordinates belongs to the shader side, not this block.

Test Plan:
- bbox (0,0)-(31,15), ack every cycle -> size 16; tiles (0,0) then (16,0) with o_last=1; o_done pulse one cycle after the second ack.
- bbox (5,5)-(6,6) -> size 2; tiles (4,4),(6,4),(4,6),(6,6); o_last only on (6,6).
- bbox (630,470)-(700,500) -> clamped to 639/479, size 16; single tile (624,464) with o_last=1.
- bbox xmin=10,xmax=5 -> no o_valid; o_done at cycle 2 after accept; o_ready=1 at cycle 3.
- bbox (0,0)-(63,63), ack low 5 cycles on the first tile -> o_valid and data stable throughout; rst asserted on tile 3 -> all outputs at reset values next cycle, no o_done.
- bbox (0,0)-(63,63), i_flush with i_ack on tile 2 -> o_valid=0 next cycle, no o_done; o_ready=1 and a new bbox accepted normally.
